// File: rtl/fpu_wb_arbiter.sv
// FPU writeback arbiter: per-source FIFOs drained round-robin onto two GPR write ports; grant-to-port is 1 cycle, push-to-port 2.
// Sources cannot be back-pressured: a registered stall warns issue logic early, and a push into a full FIFO is dropped and flagged.
module fpu_wb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic [$clog2(DEPTH):0]   cnt_nxt,
  output logic                     drop
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_ok;
  logic          push_ok;

  // A same-cycle pop frees the slot, so a full FIFO can still accept a push.
  assign pop_ok  = pop && (cnt != '0);
  assign push_ok = push && ((cnt != (AW+1)'(DEPTH)) || pop_ok);
  assign drop    = push && !push_ok;
  assign dout    = mem[rd_ptr];

  always_comb begin
    cnt_nxt = cnt;
    if (push_ok && !pop_ok)
      cnt_nxt = cnt + (AW+1)'(1);
    else if (!push_ok && pop_ok)
      cnt_nxt = cnt - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end
endmodule

module fpu_wb_arbiter #(
  parameter int N_SRC      = 14,
  parameter int DEPTH      = 4,
  parameter int STALL_FREE = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [N_SRC-1:0]      src_valid,
  input  logic [N_SRC*5-1:0]    src_rt,
  input  logic [N_SRC*32-1:0]   src_tdata,
  output logic [1:0]            wp_valid,
  output logic [9:0]            wp_rt,
  output logic [63:0]           wp_tdata,
  output logic                  stall,
  output logic                  overflow
);
  localparam int SW = $clog2(N_SRC);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [4:0]  rt;
    logic [31:0] dat;
  } res_t;

  res_t             head    [N_SRC];
  logic [CW-1:0]    cnt     [N_SRC];
  logic [CW-1:0]    cnt_nxt [N_SRC];
  logic [N_SRC-1:0] not_empty;
  logic [N_SRC-1:0] near_full;
  logic [N_SRC-1:0] pop;
  logic [N_SRC-1:0] drop;

  logic [SW-1:0]    rr_ptr;
  logic [SW-1:0]    rr_nxt;
  logic [SW-1:0]    last_idx;
  logic [SW:0]      idx_w;
  logic [SW-1:0]    scan_idx;
  logic             g0_hit;
  logic [SW-1:0]    g0_idx;
  logic             g1_cand_hit;
  logic [SW-1:0]    g1_cand;
  logic             g1_hit;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    res_t din;
    assign din = '{rt: src_rt[5*i +: 5], dat: src_tdata[32*i +: 32]};

    fpu_wb_fifo #(.W($bits(res_t)), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .push    (src_valid[i]),
      .pop     (pop[i]),
      .din     (din),
      .dout    (head[i]),
      .cnt     (cnt[i]),
      .cnt_nxt (cnt_nxt[i]),
      .drop    (drop[i])
    );

    assign not_empty[i] = (cnt[i] != '0);
    assign near_full[i] = (cnt_nxt[i] >= CW'(DEPTH - STALL_FREE));
  end

  // Rotating scan from rr_ptr; only the first two non-empty heads are considered.
  always_comb begin
    g0_hit      = 1'b0;
    g0_idx      = '0;
    g1_cand_hit = 1'b0;
    g1_cand     = '0;
    idx_w       = '0;
    scan_idx    = '0;
    for (int k = 0; k < N_SRC; k++) begin
      idx_w = {1'b0, rr_ptr} + (SW+1)'(k);
      if (idx_w >= (SW+1)'(N_SRC))
        idx_w = idx_w - (SW+1)'(N_SRC);
      scan_idx = idx_w[SW-1:0];
      if (not_empty[scan_idx]) begin
        if (!g0_hit) begin
          g0_hit = 1'b1;
          g0_idx = scan_idx;
        end else if (!g1_cand_hit) begin
          g1_cand_hit = 1'b1;
          g1_cand     = scan_idx;
        end
      end
    end
  end

  // Two writes to the same GPR in one cycle would collide, so the l port idles instead.
  assign g1_hit   = g1_cand_hit && (head[g1_cand].rt != head[g0_idx].rt);
  assign last_idx = g1_hit ? g1_cand : g0_idx;
  assign rr_nxt   = (last_idx == SW'(N_SRC - 1)) ? '0 : last_idx + SW'(1);

  always_comb begin
    pop = '0;
    if (g0_hit) pop[g0_idx]  = 1'b1;
    if (g1_hit) pop[g1_cand] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr   <= '0;
      wp_valid <= '0;
      wp_rt    <= '0;
      wp_tdata <= '0;
      stall    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wp_valid <= {g1_hit, g0_hit};
      if (g0_hit) begin
        wp_rt[4:0]     <= head[g0_idx].rt;
        wp_tdata[31:0] <= head[g0_idx].dat;
        rr_ptr         <= rr_nxt;
      end
      if (g1_hit) begin
        wp_rt[9:5]      <= head[g1_cand].rt;
        wp_tdata[63:32] <= head[g1_cand].dat;
      end
      stall    <= |near_full;
      overflow <= overflow | (|drop);
    end
  end
endmodule

// File: tb/tb_fpu_wb_arbiter.sv
// Bench for fpu_wb_arbiter: directed scenarios then randomized traffic, all checked against a queue-based reference model.
module tb_fpu_wb_arbiter;
  localparam int N = 14;
  localparam int D = 4;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    src_valid;
  logic [N*5-1:0]  src_rt;
  logic [N*32-1:0] src_tdata;
  logic [1:0]      wp_valid;
  logic [9:0]      wp_rt;
  logic [63:0]     wp_tdata;
  logic            stall;
  logic            overflow;

  fpu_wb_arbiter #(.N_SRC(N), .DEPTH(D), .STALL_FREE(2)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .src_valid (src_valid),
    .src_rt    (src_rt),
    .src_tdata (src_tdata),
    .wp_valid  (wp_valid),
    .wp_rt     (wp_rt),
    .wp_tdata  (wp_tdata),
    .stall     (stall),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one queue of {rt,data} per source plus the round-robin start.
  logic [36:0] q [N][$];
  int          m_rr;
  logic [1:0]  e_valid;
  logic [9:0]  e_rt;
  logic [63:0] e_dat;
  logic        e_stall;
  logic        e_ovf;

  logic [N-1:0]    v_w;
  logic [N*5-1:0]  rt_w;
  logic [N*32-1:0] d_w;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) q[i].delete();
    m_rr    = 0;
    e_valid = '0;
    e_rt    = '0;
    e_dat   = '0;
    e_stall = 1'b0;
    e_ovf   = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] v, input logic [N*5-1:0] rt, input logic [N*32-1:0] d);
    int first;
    int second;
    int i;
    logic [36:0] h0;
    logic [36:0] h1;
    first  = -1;
    second = -1;
    for (int k = 0; k < N; k++) begin
      i = (m_rr + k) % N;
      if (q[i].size() > 0) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    e_valid = 2'b00;
    if (first >= 0) begin
      h0 = q[first].pop_front();
      e_valid[0]  = 1'b1;
      e_rt[4:0]   = h0[36:32];
      e_dat[31:0] = h0[31:0];
      m_rr = (first + 1) % N;
      if (second >= 0) begin
        h1 = q[second][0];
        if (h1[36:32] != h0[36:32]) begin
          void'(q[second].pop_front());
          e_valid[1]   = 1'b1;
          e_rt[9:5]    = h1[36:32];
          e_dat[63:32] = h1[31:0];
          m_rr = (second + 1) % N;
        end
      end
    end
    for (int s = 0; s < N; s++) begin
      if (v[s]) begin
        if (q[s].size() < D) q[s].push_back({rt[5*s +: 5], d[32*s +: 32]});
        else e_ovf = 1'b1;
      end
    end
    e_stall = 1'b0;
    for (int s = 0; s < N; s++) if (q[s].size() >= 2) e_stall = 1'b1;
  endtask

  task automatic check_all();
    chk("wp_valid", 64'(wp_valid), 64'(e_valid));
    chk("wp_rt",    64'(wp_rt),    64'(e_rt));
    chk("wp_tdata", wp_tdata,      e_dat);
    chk("stall",    64'(stall),    64'(e_stall));
    chk("overflow", 64'(overflow), 64'(e_ovf));
  endtask

  task automatic put(input int i, input logic [4:0] rt, input logic [31:0] d);
    v_w[i]           = 1'b1;
    rt_w[5*i +: 5]   = rt;
    d_w[32*i +: 32]  = d;
  endtask

  task automatic go();
    src_valid = v_w;
    src_rt    = rt_w;
    src_tdata = d_w;
    model_step(v_w, rt_w, d_w);
    @(posedge clk);
    @(negedge clk);
    v_w       = '0;
    rt_w      = '0;
    d_w       = '0;
    src_valid = '0;
    src_rt    = '0;
    src_tdata = '0;
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) go();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    model_reset();
    chk("rst_valid", 64'(wp_valid), 64'd0);
    chk("rst_rt",    64'(wp_rt),    64'd0);
    chk("rst_tdata", wp_tdata,      64'd0);
    chk("rst_stall", 64'(stall),    64'd0);
    chk("rst_ovf",   64'(overflow), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  int dens;
  int rt_max;

  initial begin
    rstn      = 1'b0;
    src_valid = '0;
    src_rt    = '0;
    src_tdata = '0;
    v_w       = '0;
    rt_w      = '0;
    d_w       = '0;
    model_reset();
    @(negedge clk);

    // Single result: two cycles from push to write port u.
    do_reset();
    put(4, 5'd7, 32'h3F80_0000);
    go();
    chk("t1_idle_first", 64'(wp_valid), 64'd0);
    go();
    chk("t1_valid", 64'(wp_valid), 64'd1);
    chk("t1_rt",    64'(wp_rt[4:0]), 64'd7);
    chk("t1_dat",   64'(wp_tdata[31:0]), 64'h3F80_0000);
    idle(2);

    // Three simultaneous sources: 0->u, 5->l, then 9->u; rr lands on 10.
    do_reset();
    put(0, 5'd1, 32'hA000_0000);
    put(5, 5'd2, 32'hA000_0005);
    put(9, 5'd3, 32'hA000_0009);
    go();
    go();
    chk("t2_valid0", 64'(wp_valid), 64'd3);
    chk("t2_rt0",    64'(wp_rt), 64'({5'd2, 5'd1}));
    go();
    chk("t2_valid1", 64'(wp_valid), 64'd1);
    chk("t2_rt1",    64'(wp_rt[4:0]), 64'd3);
    put(3, 5'd4, 32'hB000_0003);
    put(11, 5'd5, 32'hB000_000B);
    go();
    go();
    chk("t2_rr_order", 64'(wp_rt), 64'({5'd4, 5'd5}));
    idle(2);

    // Same rt on the first two candidates: l idles, second write follows next cycle.
    do_reset();
    put(2, 5'd12, 32'h1111_2222);
    put(3, 5'd12, 32'h3333_4444);
    go();
    go();
    chk("t3_valid0", 64'(wp_valid), 64'd1);
    chk("t3_dat0",   64'(wp_tdata[31:0]), 64'h1111_2222);
    go();
    chk("t3_valid1", 64'(wp_valid), 64'd1);
    chk("t3_dat1",   64'(wp_tdata[31:0]), 64'h3333_4444);
    idle(2);

    // Flood sources 0..6 until pushes are dropped; overflow must stay set.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      for (int s = 0; s <= 6; s++) put(s, 5'(c * 7 + s), $urandom);
      go();
    end
    chk("t4_ovf", 64'(overflow), 64'd1);
    idle(10);
    chk("t4_ovf_sticky", 64'(overflow), 64'd1);

    // FIFO 1 filled while others are served, then push and pop it in the same cycle.
    do_reset();
    for (int s = 2; s < N; s++) put(s, 5'(s), 32'hC000_0000 + 32'(s));
    go();
    go();
    for (int c = 0; c < 4; c++) begin
      put(1, 5'(20 + c), 32'hD000_0000 + 32'(c));
      go();
    end
    go();
    put(1, 5'd30, 32'hD000_0004);
    go();
    chk("t5_valid", 64'(wp_valid), 64'd1);
    chk("t5_oldest", 64'(wp_tdata[31:0]), 64'hD000_0000);
    chk("t5_no_ovf", 64'(overflow), 64'd0);
    idle(6);

    // Reset in the middle of a burst.
    do_reset();
    for (int c = 0; c < 2; c++) begin
      for (int s = 0; s < 3; s++) put(s, 5'(c * 3 + s), $urandom);
      go();
    end
    do_reset();
    idle(4);
    chk("t6_quiet", 64'(wp_valid), 64'd0);

    // Random traffic at several densities; narrow rt range forces same-rt collisions.
    for (int ph = 0; ph < 4; ph++) begin
      do_reset();
      dens   = (ph == 0) ? 5 : (ph == 1) ? 15 : (ph == 2) ? 30 : 60;
      rt_max = (ph == 2) ? 3 : 31;
      for (int c = 0; c < 100; c++) begin
        for (int s = 0; s < N; s++)
          if (int'($urandom_range(99)) < dens)
            put(s, 5'($urandom_range(rt_max)), $urandom);
        go();
      end
      idle(10);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
